fb_mem_arbiter: RTL
===================

# fb_mem_arbiter

Shares the single-port frame-buffer memory between three requesters: NTSC scan-out reader, USB capture writer, and UART debug port. Issues at most one access per cycle and gives scan-out strict priority so the video line never underruns. Round-robins the two low-priority requesters between themselves. Returns read data to the correct owner through a tagged, fixed-latency return pipeline. Sits between the video/USB/UART datapaths and the memory primitive inside `virtual_crt_top`.

## Interface
- `ADDR_W`, 16, memory word address width
- `DATA_W`, 8, memory data width
- `MEM_LAT`, 2, cycles from `mem_en` (read) to valid `mem_rdata`; legal range 1..4
- `STARVE_MAX`, 64, wait cycles after which a pending low-priority request raises `starve`

- `clk`  in  1  single clock; all logic on rising edge
- `rst`  in  1  synchronous, active-high reset
- `sc_req`  in  1  scan-out read request; `sc_addr` held stable while high
- `sc_addr`  in  ADDR_W  scan-out read address
- `sc_gnt`  out  1  request accepted this cycle
- `sc_rvalid`  out  1  `sc_rdata` valid
- `sc_rdata`  out  DATA_W  scan-out read data
- `usb_req`  in  1  USB write request; `usb_addr`, `usb_wdata` held while high
- `usb_addr`  in  ADDR_W  write address
- `usb_wdata`  in  DATA_W  write data
- `usb_gnt`  out  1  write accepted this cycle
- `dbg_req`  in  1  debug access request; `dbg_we`, `dbg_addr`, `dbg_wdata` held while high
- `dbg_we`  in  1  1 = write, 0 = read
- `dbg_addr`  in  ADDR_W  debug address
- `dbg_wdata`  in  DATA_W  debug write data
- `dbg_gnt`  out  1  access accepted this cycle
- `dbg_rvalid`  out  1  `dbg_rdata` valid (reads only)
- `dbg_rdata`  out  DATA_W  debug read data
- `mem_en`, `mem_we`  out  1  registered memory strobe and write enable
- `mem_addr`  out  ADDR_W  registered address
- `mem_wdata`  out  DATA_W  registered write data
- `mem_rdata`  in  DATA_W  memory read data
- `starve`  out  1  sticky; set when usb or dbg waits ≥ STARVE_MAX cycles; cleared only by `rst`

## Operation
- Grant is combinational in cycle N from the `*_req` inputs and the round-robin pointer; exactly one or zero `*_gnt` high per cycle.
- Priority: `sc_req` wins unconditionally. Otherwise usb/dbg arbitrate round-robin.
  - `rr_ptr` points at the preferred low requester; reset value = usb.
  - After a usb or dbg grant, `rr_ptr` moves to the other one. A scan-out grant leaves it unchanged.
  - A lone requester is granted regardless of `rr_ptr`.
- Requester drops or changes its request only in the cycle after `*_gnt`. The arbiter never latches an ungranted request.
- Issue register: in cycle N+1, `mem_en`=1 with the granted `mem_we`/`mem_addr`/`mem_wdata`. `mem_en`=0 in idle cycles; `mem_addr` and `mem_wdata` hold their last value.
- Return pipeline: a MEM_LAT-deep shift register of {valid, owner} tags. Only reads enter it (scan-out, or dbg with `dbg_we`=0).
  - When a tag reaches the end, the owner's `*_rvalid` pulses for one cycle with `*_rdata` = `mem_rdata`, registered.
  - The non-owner `*_rdata` holds its previous value.
- Writes never produce `rvalid`.
- Starvation counters: one per low requester, width ⌈log2(STARVE_MAX+1)⌉.
  - Increments while req high and not granted; saturates at STARVE_MAX.
  - Clears on grant or when req is low.
  - `starve` is set on reaching STARVE_MAX. It is status only and never overrides scan-out priority.

## Timing
- Reset values: all `*_gnt`, `*_rvalid`, `mem_en`, `mem_we`, `starve` = 0; `mem_addr`, `mem_wdata`, `*_rdata` = 0; tags cleared; `rr_ptr` = usb; counters = 0.
- Read latency: `*_gnt` in cycle N → `*_rvalid` in cycle N+2+MEM_LAT.
- Write latency: `usb_gnt` in cycle N → memory write strobe in cycle N+1.
- Throughput: one access per cycle. Back-to-back grants to the same requester are legal.
- `rst` asserted mid-operation: in-flight tags are discarded, so no `rvalid` is produced for reads issued before reset. `mem_en`=0 in the cycle after `rst`. A grant is possible in the first cycle `rst` is low.
- Simultaneous `sc_req`, `usb_req` and `dbg_req`: `sc_gnt`=1 only, and `rr_ptr` is unchanged.
- `rst` and `req` high in the same cycle: no grant.

## Test plan
- Reset then idle: all outputs 0. Single `sc_req` at addr 0x0010, memory returning 0xA5 → `sc_gnt` in cycle 0, `mem_en`/`mem_addr`=0x0010 in cycle 1, `sc_rvalid` with 0xA5 in cycle 4 (MEM_LAT=2).
- `usb_req` and `dbg_req` held high for 6 cycles, no scan-out → grants alternate usb, dbg, usb, dbg, usb, dbg. `mem_we` follows each owner's write enable.
- `sc_req` held for 70 cycles while `usb_req` is pending → only `sc_gnt` for 70 cycles, `starve`=1 from the usb wait count of 64 onward, and usb granted in cycle 70.
- Interleaved scan-out reads and dbg reads, with the memory model returning address-derived data → every `rvalid` reaches the correct owner, in order, with matching data. No `rvalid` is produced for dbg writes.
- Issue 2 reads, assert `rst` one cycle later for 1 cycle → zero `rvalid` pulses afterward. `starve`, `mem_en` and `rr_ptr` are back at reset values.
- Sweep MEM_LAT=1 and MEM_LAT=4 → read latency is 3 and 6 cycles respectively, with no lost or duplicated returns at full-rate issue.

Source files
------------

// File: rtl/fb_mem_arbiter.sv
// Frame-buffer memory arbiter: scan-out has strict priority, usb/dbg share the rest round-robin.
// Read data returns to its owner through a tagged pipeline matched to the memory latency.
module fb_mem_arbiter #(
  parameter int unsigned ADDR_W     = 16,
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned MEM_LAT    = 2,
  parameter int unsigned STARVE_MAX = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sc_req,
  input  logic [ADDR_W-1:0] sc_addr,
  output logic              sc_gnt,
  output logic              sc_rvalid,
  output logic [DATA_W-1:0] sc_rdata,
  input  logic              usb_req,
  input  logic [ADDR_W-1:0] usb_addr,
  input  logic [DATA_W-1:0] usb_wdata,
  output logic              usb_gnt,
  input  logic              dbg_req,
  input  logic              dbg_we,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [DATA_W-1:0] dbg_wdata,
  output logic              dbg_gnt,
  output logic              dbg_rvalid,
  output logic [DATA_W-1:0] dbg_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              starve
);

  localparam int unsigned CntW = $clog2(STARVE_MAX + 1);
  localparam logic [CntW-1:0] CntMax = CntW'(STARVE_MAX);

  typedef enum logic {RrUsb, RrDbg} rr_e;
  typedef enum logic {OwnSc, OwnDbg} own_e;

  rr_e               rr_q, rr_d;
  logic              iss_en_d, iss_we_d;
  logic [ADDR_W-1:0] addr_d;
  logic [DATA_W-1:0] wdata_d;
  logic              rd_v_d, iss_v_q;
  own_e              rd_own_d, iss_own_q;
  logic [MEM_LAT-1:0] tag_v_q;
  own_e              tag_own_q [MEM_LAT];
  logic              end_v;
  own_e              end_own;
  logic [CntW-1:0]   usb_cnt_q, usb_cnt_d, dbg_cnt_q, dbg_cnt_d;
  logic              starve_d;

  // Grant is purely combinational; reset suppresses every grant.
  always_comb begin
    sc_gnt  = 1'b0;
    usb_gnt = 1'b0;
    dbg_gnt = 1'b0;
    if (!rst) begin
      if (sc_req) begin
        sc_gnt = 1'b1;
      end else if (usb_req && (!dbg_req || rr_q == RrUsb)) begin
        usb_gnt = 1'b1;
      end else if (dbg_req) begin
        dbg_gnt = 1'b1;
      end
    end
  end

  always_comb begin
    rr_d     = rr_q;
    iss_en_d = sc_gnt | usb_gnt | dbg_gnt;
    iss_we_d = usb_gnt | (dbg_gnt & dbg_we);
    addr_d   = mem_addr;
    wdata_d  = mem_wdata;
    rd_v_d   = sc_gnt | (dbg_gnt & ~dbg_we);
    rd_own_d = dbg_gnt ? OwnDbg : OwnSc;
    if (sc_gnt) begin
      addr_d = sc_addr;
    end else if (usb_gnt) begin
      addr_d  = usb_addr;
      wdata_d = usb_wdata;
      rr_d    = RrDbg;
    end else if (dbg_gnt) begin
      addr_d = dbg_addr;
      if (dbg_we) wdata_d = dbg_wdata;
      rr_d = RrUsb;
    end
  end

  always_comb begin
    usb_cnt_d = '0;
    dbg_cnt_d = '0;
    if (usb_req && !usb_gnt) begin
      usb_cnt_d = (usb_cnt_q == CntMax) ? usb_cnt_q : usb_cnt_q + 1'b1;
    end
    if (dbg_req && !dbg_gnt) begin
      dbg_cnt_d = (dbg_cnt_q == CntMax) ? dbg_cnt_q : dbg_cnt_q + 1'b1;
    end
    starve_d = starve | (usb_cnt_d == CntMax) | (dbg_cnt_d == CntMax);
  end

  assign end_v   = tag_v_q[MEM_LAT-1];
  assign end_own = tag_own_q[MEM_LAT-1];

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_q       <= RrUsb;
      mem_en     <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      iss_v_q    <= 1'b0;
      iss_own_q  <= OwnSc;
      tag_v_q    <= '0;
      for (int i = 0; i < MEM_LAT; i++) tag_own_q[i] <= OwnSc;
      sc_rvalid  <= 1'b0;
      dbg_rvalid <= 1'b0;
      sc_rdata   <= '0;
      dbg_rdata  <= '0;
      usb_cnt_q  <= '0;
      dbg_cnt_q  <= '0;
      starve     <= 1'b0;
    end else begin
      rr_q      <= rr_d;
      mem_en    <= iss_en_d;
      mem_we    <= iss_we_d;
      mem_addr  <= addr_d;
      mem_wdata <= wdata_d;
      // Tag stage iss_* rides alongside mem_en; the MEM_LAT stages follow the memory.
      iss_v_q   <= rd_v_d;
      iss_own_q <= rd_own_d;
      tag_v_q[0]   <= iss_v_q;
      tag_own_q[0] <= iss_own_q;
      for (int i = 1; i < MEM_LAT; i++) begin
        tag_v_q[i]   <= tag_v_q[i-1];
        tag_own_q[i] <= tag_own_q[i-1];
      end
      sc_rvalid  <= end_v && (end_own == OwnSc);
      dbg_rvalid <= end_v && (end_own == OwnDbg);
      if (end_v && end_own == OwnSc) sc_rdata <= mem_rdata;
      if (end_v && end_own == OwnDbg) dbg_rdata <= mem_rdata;
      usb_cnt_q <= usb_cnt_d;
      dbg_cnt_q <= dbg_cnt_d;
      starve    <= starve_d;
    end
  end

endmodule
